// File: rtl/dac_sample_scheduler_pkg.sv
// Shared constants, state encodings and the round-robin pick helper
// for the DAC sample scheduler.
package dac_sched_pkg;

  localparam int NUM_CH         = 2;
  localparam int DEF_DATA_W     = 10;
  localparam int DEF_SPI_CYCLES = 1000;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t IDLE = 2'd0;
  localparam sched_state_t LOAD = 2'd1;
  localparam sched_state_t WAIT = 2'd2;

  // A tie goes to the channel not served last; otherwise the lone eligible one.
  function automatic logic pick_ch(input logic [NUM_CH-1:0] elig, input logic last);
    if (elig == 2'b11) return ~last;
    return elig[1];
  endfunction

endpackage

// File: rtl/dac_sample_scheduler_if.sv
// Sample producer side of the scheduler: level requests, sample data and
// the per-channel acknowledge pulse.
interface dac_sample_scheduler_if
  import dac_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [NUM_CH-1:0] req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [NUM_CH-1:0] ack;

  modport master (output req, output data0, output data1, input ack);
  modport slave  (input req, input data0, input data1, output ack);
endinterface

// File: rtl/dac_sample_scheduler_spi_hold_timer.sv
// Loadable down-counter that holds off the next DAC load until the
// current SPI frame has had time to finish.
module spi_hold_timer #(
  parameter int SPI_CYCLES = 1000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic load,
  output logic done
);
  localparam int CW = $clog2(SPI_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= CW'(SPI_CYCLES - 1);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/dac_sample_scheduler.sv
// Shares one spi2dac between two sample channels: each tick starts a round
// serving every requesting channel once, round-robin, spaced by SPI_CYCLES.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SPI_CYCLES = DEF_SPI_CYCLES
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   tick,
  dac_sample_scheduler_if.slave  src,
  output logic [DATA_W-1:0]      dac_data,
  output logic                   dac_load,
  output logic                   busy,
  output logic                   overrun
);
  sched_state_t      state;
  logic [NUM_CH-1:0] pend;
  logic              last;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] sel_mask;
  logic              sel;
  logic              go_load;
  logic              hold_done;

  // In IDLE the snapshot is being taken this very edge, so the live req is the pend.
  always_comb begin
    elig     = '0;
    sel      = 1'b0;
    sel_mask = '0;
    go_load  = 1'b0;
    if (state == IDLE) begin
      elig    = src.req;
      go_load = tick && (src.req != '0);
    end else if (state == WAIT) begin
      elig    = pend & src.req;
      go_load = hold_done && (elig != '0);
    end
    sel      = pick_ch(elig, last);
    sel_mask = sel ? 2'b10 : 2'b01;
  end

  assign overrun = tick && (state != IDLE);

  spi_hold_timer #(.SPI_CYCLES(SPI_CYCLES)) u_hold_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .load   (go_load),
    .done   (hold_done)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      last     <= 1'b1;
      dac_data <= '0;
      dac_load <= 1'b0;
      src.ack  <= '0;
      busy     <= 1'b0;
    end else begin
      dac_load <= go_load;
      src.ack  <= go_load ? sel_mask : '0;
      if (go_load) begin
        state    <= LOAD;
        busy     <= 1'b1;
        dac_data <= sel ? src.data1 : src.data0;
        last     <= sel;
        // Channels whose req dropped since the snapshot are discarded here too.
        pend     <= elig & ~sel_mask;
      end else begin
        case (state)
          LOAD: begin
            state <= WAIT;
            busy  <= 1'b1;
          end
          WAIT: begin
            if (hold_done) begin
              state <= IDLE;
              busy  <= 1'b0;
              pend  <= '0;
            end
          end
          IDLE: begin
            pend <= '0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            pend  <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler with SPI_CYCLES = 8.
module tb_dac_sample_scheduler;
  localparam int DW = 10;
  localparam int SC = 8;

  logic          sysclk = 1'b0;
  logic          reset  = 1'b1;
  logic          tick   = 1'b0;
  logic [DW-1:0] dac_data;
  logic          dac_load;
  logic          busy;
  logic          overrun;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  dac_sample_scheduler_if #(.DATA_W(DW)) bus ();

  dac_sample_scheduler #(.DATA_W(DW), .SPI_CYCLES(SC)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .tick     (tick),
    .src      (bus),
    .dac_data (dac_data),
    .dac_load (dac_load),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [1:0]    ack;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]    req;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int            n;
    logic          first;
    logic [DW-1:0] data_after;
  } vec_t;
  vec_t vecs[7];

  // Every load must match the oldest expected load in cycle, channel and data.
  always @(negedge sysclk) begin
    if (dac_load) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: cycle %0d ack %b data %h, none expected", cyc, bus.ack, dac_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (cyc != e.c || bus.ack !== e.ack || dac_data !== e.data) begin
          errors++;
          $display("FAIL load: got cycle %0d ack %b data %h, expected cycle %0d ack %b data %h",
                   cyc, bus.ack, dac_data, e.c, e.ack, e.data);
        end
      end
    end else if (bus.ack != 2'b00) begin
      errors++;
      $display("FAIL ack_without_load: cycle %0d ack %b", cyc, bus.ack);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic go_cyc(input int c);
    while (cyc < c) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic push_load(input int c, input logic ch, input logic [DW-1:0] d);
    exp_t e;
    e.c    = c;
    e.ack  = ch ? 2'b10 : 2'b01;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge sysclk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    int t;
    vecs[0] = '{2'b11, 10'h3FF, 10'h001, 2, 1'b0, 10'h001};
    vecs[1] = '{2'b11, 10'h123, 10'h0AB, 2, 1'b0, 10'h0AB};
    vecs[2] = '{2'b01, 10'h155, 10'h2AA, 1, 1'b0, 10'h155};
    vecs[3] = '{2'b11, 10'h0F0, 10'h00F, 2, 1'b1, 10'h0F0};
    vecs[4] = '{2'b10, 10'h111, 10'h200, 1, 1'b1, 10'h200};
    vecs[5] = '{2'b00, 10'h3C3, 10'h0C3, 0, 1'b0, 10'h200};
    vecs[6] = '{2'b11, 10'h2A5, 10'h15A, 2, 1'b0, 10'h15A};

    bus.req   = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;
    go_cyc(3);
    #2;
    chk("reset_outputs", 32'({dac_data, dac_load, bus.ack, busy, overrun}), 32'h0);
    go_cyc(4);
    reset = 1'b0;

    // Row 0 ticks in the very first IDLE cycle after reset.
    for (int i = 0; i < 7; i++) begin
      t = cyc;
      bus.req   = vecs[i].req;
      bus.data0 = vecs[i].d0;
      bus.data1 = vecs[i].d1;
      if (vecs[i].n >= 1)
        push_load(t + 1, vecs[i].first, vecs[i].first ? vecs[i].d1 : vecs[i].d0);
      if (vecs[i].n == 2)
        push_load(t + 1 + SC, ~vecs[i].first, vecs[i].first ? vecs[i].d0 : vecs[i].d1);
      pulse_tick();
      #2;
      chk("busy_after_tick", 32'(busy), 32'(vecs[i].n > 0));
      if (vecs[i].n > 0) begin
        go_cyc(t + SC * vecs[i].n);
        #2;
        chk("busy_last_wait", 32'(busy), 32'h1);
        go_cyc(t + 1 + SC * vecs[i].n);
        #2;
        chk("busy_back_idle", 32'(busy), 32'h0);
      end else begin
        go_cyc(t + 3);
        #2;
        chk("busy_no_req", 32'(busy), 32'h0);
      end
      chk("dac_data_after_round", 32'(dac_data), 32'(vecs[i].data_after));
      bus.req = 2'b00;
      go_cyc(cyc + 3);
    end

    // Channel 1 drops its request before its turn.
    t = cyc;
    bus.req = 2'b11; bus.data0 = 10'h0AA; bus.data1 = 10'h355;
    push_load(t + 1, 1'b0, 10'h0AA);
    pulse_tick();
    go_cyc(t + 4);
    bus.req = 2'b01;
    go_cyc(t + 9);
    #2;
    chk("drop_idle_at_t9", 32'(busy), 32'h0);
    go_cyc(t + 17);
    chk("drop_no_second_load", 32'(sb.size()), 32'h0);
    bus.req = 2'b00;
    go_cyc(cyc + 3);

    // Overrun: ch0 was served last, so ch1 goes first.
    t = cyc;
    bus.req = 2'b11; bus.data0 = 10'h101; bus.data1 = 10'h202;
    push_load(t + 1, 1'b1, 10'h202);
    push_load(t + 1 + SC, 1'b0, 10'h101);
    tick = 1'b1;
    #2;
    chk("overrun_idle_tick", 32'(overrun), 32'h0);
    @(posedge sysclk); #1;
    tick = 1'b0;
    go_cyc(t + 5);
    tick = 1'b1;
    #2;
    chk("overrun_pulse", 32'(overrun), 32'h1);
    @(posedge sysclk); #1;
    tick = 1'b0;
    #2;
    chk("overrun_one_cycle", 32'(overrun), 32'h0);
    go_cyc(t + 17);
    #2;
    chk("overrun_round_done", 32'(busy), 32'h0);
    chk("overrun_two_loads", 32'(sb.size()), 32'h0);
    bus.req = 2'b00;
    go_cyc(cyc + 3);

    // Reset in the middle of a round.
    t = cyc;
    bus.req = 2'b11; bus.data0 = 10'h0C0; bus.data1 = 10'h30C;
    push_load(t + 1, 1'b1, 10'h30C);
    pulse_tick();
    go_cyc(t + 4);
    reset = 1'b1;
    go_cyc(t + 5);
    #2;
    chk("reset_mid_round_outputs", 32'({dac_data, dac_load, bus.ack, busy, overrun}), 32'h0);
    go_cyc(t + 6);
    reset = 1'b0;
    go_cyc(t + 12);
    #2;
    chk("reset_mid_round_idle", 32'(busy), 32'h0);
    t = cyc;
    push_load(t + 1, 1'b0, 10'h0C0);
    push_load(t + 1 + SC, 1'b1, 10'h30C);
    pulse_tick();
    go_cyc(t + 17);
    bus.req = 2'b00;
    go_cyc(cyc + 3);

    // Leave ch0 as last served, then reset while idle: a tie must go to ch0 again.
    t = cyc;
    bus.req = 2'b01; bus.data0 = 10'h01E;
    push_load(t + 1, 1'b0, 10'h01E);
    pulse_tick();
    go_cyc(t + 10);
    bus.req = 2'b00;
    reset = 1'b1;
    go_cyc(t + 11);
    reset = 1'b0;
    go_cyc(t + 12);
    t = cyc;
    bus.req = 2'b11; bus.data0 = 10'h0E1; bus.data1 = 10'h31E;
    push_load(t + 1, 1'b0, 10'h0E1);
    push_load(t + 1 + SC, 1'b1, 10'h31E);
    pulse_tick();
    go_cyc(t + 17);
    #2;
    chk("last_reset_round_done", 32'(busy), 32'h0);
    bus.req = 2'b00;
    go_cyc(cyc + 3);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
